// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - time-set sequencer: button debounce, RUN/SET FSM, tick gating, field pulses
// Buttons are synchronised and debounced; press events drive the mode FSM and the increment pulses.
module clock_set_controller #(
    parameter int DEB_CYCLES = 16,
    parameter int TIMEOUT_S  = 30
) (
    input  logic       clkmain,
    input  logic       clear,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       sec_en,
    output logic       hr_inc,
    output logic       min_inc,
    output logic       sec_clr,
    output logic       set_time,
    output logic [1:0] field_sel,
    output logic       blink
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [CW-1:0] CLIM = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_S);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } state_t;

    state_t          state;
    logic [1:0]      raw;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      deb;
    logic [1:0]      press;
    logic [CW-1:0]   cnt [2];
    logic [TW-1:0]   tcnt;
    logic            mode_press;
    logic            inc_press;
    logic            timed_out;

    assign raw        = {inc_btn, mode_btn};
    assign mode_press = press[0];
    assign inc_press  = press[1];
    assign field_sel  = state;
    assign timed_out  = (TIMEOUT_S != 0) && (tcnt == TLIM);

    // Index 0 is the mode button, index 1 the increment button.
    always_ff @(posedge clkmain or posedge clear) begin
        if (clear) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CLIM) begin
                    cnt[i]   <= '0;
                    deb[i]   <= s2[i];
                    press[i] <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkmain or posedge clear) begin
        if (clear) begin
            state    <= RUN;
            set_time <= 1'b0;
            blink    <= 1'b0;
            tcnt     <= '0;
            sec_en   <= 1'b0;
            hr_inc   <= 1'b0;
            min_inc  <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            hr_inc  <= 1'b0;
            min_inc <= 1'b0;
            sec_clr <= 1'b0;
            sec_en  <= tick_1hz && (state == RUN);
            if (state == RUN) begin
                blink <= 1'b0;
                tcnt  <= '0;
                if (mode_press) begin
                    state    <= SET_HR;
                    set_time <= 1'b1;
                end
            end else if (timed_out) begin
                state    <= RUN;
                set_time <= 1'b0;
                blink    <= 1'b0;
                tcnt     <= '0;
            end else if (mode_press) begin
                // Mode wins over a same-cycle inc press; the inc event is simply dropped.
                blink <= 1'b0;
                tcnt  <= '0;
                case (state)
                    SET_HR:  state <= SET_MIN;
                    SET_MIN: state <= SET_SEC;
                    default: state <= RUN;
                endcase
                set_time <= (state != SET_SEC);
            end else begin
                if (inc_press) begin
                    tcnt <= '0;
                    case (state)
                        SET_HR:  hr_inc  <= 1'b1;
                        SET_MIN: min_inc <= 1'b1;
                        default: sec_clr <= 1'b1;
                    endcase
                end else if (tick_1hz && (TIMEOUT_S != 0)) begin
                    tcnt <= tcnt + 1'b1;
                end
                if (tick_1hz) blink <= ~blink;
            end
        end
    end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed bench for clock_set_controller
// Runs with a short debounce (4) and timeout (3) so every scenario stays brief.
module tb_clock_set_controller;
    localparam int DEB = 4;
    localparam int TMO = 3;

    logic       clkmain = 1'b0;
    logic       clear = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       sec_en;
    logic       hr_inc;
    logic       min_inc;
    logic       sec_clr;
    logic       set_time;
    logic [1:0] field_sel;
    logic       blink;

    int checks = 0;
    int failures = 0;
    int n_hr = 0, n_min = 0, n_clr = 0, n_sec = 0, n_incev = 0, n_multi = 0;

    clock_set_controller #(.DEB_CYCLES(DEB), .TIMEOUT_S(TMO)) dut (
        .clkmain(clkmain), .clear(clear), .tick_1hz(tick_1hz),
        .mode_btn(mode_btn), .inc_btn(inc_btn), .sec_en(sec_en),
        .hr_inc(hr_inc), .min_inc(min_inc), .sec_clr(sec_clr),
        .set_time(set_time), .field_sel(field_sel), .blink(blink)
    );

    always #5 clkmain = ~clkmain;

    always @(negedge clkmain) begin
        if (hr_inc) n_hr++;
        if (min_inc) n_min++;
        if (sec_clr) n_clr++;
        if (sec_en) n_sec++;
        if (dut.inc_press) n_incev++;
        if (int'(hr_inc) + int'(min_inc) + int'(sec_clr) + int'(sec_en) > 1) n_multi++;
    end

    task automatic step();
        @(posedge clkmain);
        #1;
    endtask

    task automatic set_raw(input int which, input logic v);
        if (which == 0 || which == 2) mode_btn = v;
        if (which == 1 || which == 2) inc_btn = v;
    endtask

    // which: 0 mode, 1 inc, 2 both; glitches shorter than DEB precede the steady press.
    task automatic press_btn(input int which, input int glitches);
        for (int g = 0; g < glitches; g++) begin
            set_raw(which, 1'b1);
            step(); step();
            set_raw(which, 1'b0);
            step();
        end
        set_raw(which, 1'b1);
        repeat (DEB + 4) step();
        set_raw(which, 1'b0);
        repeat (DEB + 4) step();
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic check_fs(input string name, input logic [1:0] exp_fs, input logic exp_st);
        checks++;
        if (field_sel !== exp_fs || set_time !== exp_st) begin
            failures++;
            $display("FAIL %s: field_sel=%b set_time=%b required field_sel=%b set_time=%b",
                     name, field_sel, set_time, exp_fs, exp_st);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({sec_en, hr_inc, min_inc, sec_clr, set_time, field_sel, blink} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {sec_en, hr_inc, min_inc, sec_clr, set_time, field_sel, blink});
        end
        clear = 1'b0;
        repeat (3) step();
        check_fs("reset_release", 2'b00, 1'b0);
    endtask

    task automatic test_run_ticks();
        int s0;
        s0 = n_sec;
        for (int t = 0; t < 3; t++) begin
            repeat (99) step();
            do_tick();
            checks++;
            if (sec_en !== 1'b1) begin
                failures++;
                $display("FAIL run_sec_en_pulse[%0d]: got %b required 1", t, sec_en);
            end
            step();
            checks++;
            if (sec_en !== 1'b0) begin
                failures++;
                $display("FAIL run_sec_en_width[%0d]: got %b required 0", t, sec_en);
            end
        end
        checks++;
        if (n_sec - s0 !== 3) begin
            failures++;
            $display("FAIL run_sec_en_count: got %0d required 3", n_sec - s0);
        end
        check_fs("run_state", 2'b00, 1'b0);
    endtask

    task automatic test_set_hr();
        int h0, s0;
        press_btn(0, 0);
        check_fs("set_hr_entry", 2'b01, 1'b1);
        h0 = n_hr;
        s0 = n_sec;
        press_btn(1, 5);
        do_tick();
        repeat (3) step();
        press_btn(1, 5);
        press_btn(1, 5);
        check_fs("set_hr_stays", 2'b01, 1'b1);
        checks++;
        if (n_hr - h0 !== 3) begin
            failures++;
            $display("FAIL set_hr_inc_count: got %0d required 3", n_hr - h0);
        end
        checks++;
        if (n_sec - s0 !== 0) begin
            failures++;
            $display("FAIL set_hr_sec_en_frozen: got %0d required 0", n_sec - s0);
        end
    endtask

    task automatic test_set_fields();
        int h0, m0, c0, s0;
        h0 = n_hr; m0 = n_min; c0 = n_clr;
        press_btn(0, 0);
        check_fs("set_min_entry", 2'b10, 1'b1);
        press_btn(1, 0);
        checks++;
        if (n_min - m0 !== 1 || n_hr - h0 !== 0 || n_clr - c0 !== 0) begin
            failures++;
            $display("FAIL set_min_pulses: min=%0d hr=%0d clr=%0d required 1 0 0",
                     n_min - m0, n_hr - h0, n_clr - c0);
        end
        press_btn(0, 0);
        check_fs("set_sec_entry", 2'b11, 1'b1);
        press_btn(1, 0);
        checks++;
        if (n_clr - c0 !== 1 || n_min - m0 !== 1) begin
            failures++;
            $display("FAIL set_sec_pulses: clr=%0d min=%0d required 1 1", n_clr - c0, n_min - m0);
        end
        press_btn(0, 0);
        check_fs("back_to_run", 2'b00, 1'b0);
        s0 = n_sec;
        do_tick();
        checks++;
        if (sec_en !== 1'b1) begin
            failures++;
            $display("FAIL run_resume_sec_en: got %b required 1", sec_en);
        end
        step();
        checks++;
        if (n_sec - s0 !== 1) begin
            failures++;
            $display("FAIL run_resume_count: got %0d required 1", n_sec - s0);
        end
    endtask

    task automatic test_timeout();
        logic exp_blink;
        int h0;
        press_btn(0, 0);
        check_fs("timeout_entry", 2'b01, 1'b1);
        h0 = n_hr;
        exp_blink = 1'b0;
        for (int t = 0; t < 3; t++) begin
            repeat (4) step();
            do_tick();
            exp_blink = ~exp_blink;
            checks++;
            if (blink !== exp_blink) begin
                failures++;
                $display("FAIL timeout_blink[%0d]: got %b required %b", t, blink, exp_blink);
            end
        end
        check_fs("timeout_not_yet", 2'b01, 1'b1);
        step();
        check_fs("timeout_to_run", 2'b00, 1'b0);
        checks++;
        if (blink !== 1'b0 || n_hr - h0 !== 0) begin
            failures++;
            $display("FAIL timeout_quiet: blink=%b hr_pulses=%0d required 0 0", blink, n_hr - h0);
        end
    endtask

    task automatic test_simultaneous();
        int h0, m0;
        press_btn(0, 0);
        check_fs("simul_entry", 2'b01, 1'b1);
        h0 = n_hr; m0 = n_min;
        press_btn(2, 0);
        check_fs("simul_mode_wins", 2'b10, 1'b1);
        checks++;
        if (n_hr - h0 !== 0 || n_min - m0 !== 0) begin
            failures++;
            $display("FAIL simul_inc_dropped: hr=%0d min=%0d required 0 0", n_hr - h0, n_min - m0);
        end
    endtask

    task automatic test_clear_mid_set();
        int lat, e0, h0, m0, c0;
        check_fs("clear_pre_state", 2'b10, 1'b1);
        inc_btn = 1'b1;
        repeat (DEB + 4) step();
        clear = 1'b1;
        #1;
        checks++;
        if ({sec_en, hr_inc, min_inc, sec_clr, set_time, field_sel, blink} !== 8'b0) begin
            failures++;
            $display("FAIL clear_outputs: got %b required 00000000",
                     {sec_en, hr_inc, min_inc, sec_clr, set_time, field_sel, blink});
        end
        repeat (3) step();
        e0 = n_incev; h0 = n_hr; m0 = n_min; c0 = n_clr;
        clear = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (lat < 0 && dut.inc_press) lat = k;
        end
        checks++;
        if (lat < DEB + 1 || lat > DEB + 3) begin
            failures++;
            $display("FAIL clear_release_latency: got %0d required %0d..%0d", lat, DEB + 1, DEB + 3);
        end
        checks++;
        if (n_incev - e0 !== 1) begin
            failures++;
            $display("FAIL clear_release_events: got %0d required 1", n_incev - e0);
        end
        checks++;
        if (n_hr - h0 !== 0 || n_min - m0 !== 0 || n_clr - c0 !== 0) begin
            failures++;
            $display("FAIL clear_release_no_pulse: hr=%0d min=%0d clr=%0d required 0 0 0",
                     n_hr - h0, n_min - m0, n_clr - c0);
        end
        check_fs("clear_release_run", 2'b00, 1'b0);
        inc_btn = 1'b0;
        repeat (DEB + 4) step();
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_set_hr();
        test_set_fields();
        test_timeout();
        test_simultaneous();
        test_clear_mid_set();
        checks++;
        if (n_multi !== 0) begin
            failures++;
            $display("FAIL exclusive_pulses: got %0d overlapping cycles required 0", n_multi);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
